// File: rtl/imem_ext_loader_pkg.sv
// Shared types and constants for the instruction-memory external-port loader.
// VERIFY/ERR states exist only when IMEM_LOADER_VERIFY_EN is defined.
package imem_loader_pkg;

    localparam int ADDR_STRIDE_DEF = 4;
    localparam int RD_LAT          = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN
`ifdef IMEM_LOADER_VERIFY_EN
        ,
        VERIFY,
        ERR
`endif
    } state_t;

endpackage

// File: rtl/imem_ext_loader_if.sv
// Instruction stream plus external imem port. The loader is the master side;
// the host/stream source and the memory form the slave side.
interface imem_ext_loader_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;

    modport master (
        input  s_valid, s_data, rdata_ext,
        output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );

    modport slave (
        output s_valid, s_data, rdata_ext,
        input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );
endinterface

// File: rtl/imem_loader_addr_gen.sv
// Base/count latch and word index; addr is base + idx*ADDR_STRIDE modulo 2^ADDR_W.
// Shared by the write (LOAD) and read-back (VERIFY) passes via rewind.
module imem_loader_addr_gen #(
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 10,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              rewind,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            base_q <= '0;
            cnt_q  <= '0;
            idx    <= '0;
        end else if (load) begin
            base_q <= base_addr;
            cnt_q  <= word_count;
            idx    <= '0;
        end else if (rewind) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + CNT_W'(1);
        end
    end

    assign addr = base_q + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
    assign last = (idx == cnt_q - CNT_W'(1));

endmodule

// File: rtl/imem_ext_loader.sv
// Streams instruction words into imem through the external port, then enables the CPU.
// Define IMEM_LOADER_VERIFY_EN to add a read-back pass checked with a running XOR checksum.
module imem_ext_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 10,
    parameter int ADDR_STRIDE = ADDR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    imem_ext_loader_if.master bus,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);
    state_t            state;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last;
    logic              ag_load;
    logic              ag_rewind;
    logic              ag_step;

`ifdef IMEM_LOADER_VERIFY_EN
    // The shadow is an XOR of every word written; the read-back XOR must equal it.
    // A mismatch is therefore reported once the last read returns.
    logic              rd_done;
    logic              rd_issue;
    logic [DATA_W-1:0] wr_sum;
    logic [DATA_W-1:0] rd_sum;
    logic [RD_LAT:0]   vld_pipe;
    logic [RD_LAT:0]   last_pipe;

    assign rd_issue = (state == VERIFY) && !rd_done;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[RD_LAT-1:0], rd_issue};
            last_pipe <= {last_pipe[RD_LAT-1:0], rd_issue && ag_last};
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.rdata_ext;
`endif

    assign ag_load   = start && !busy && (word_count != '0);
    assign ag_rewind = (state == LOAD) && !bus.s_ready;

    always_comb begin
        ag_step = (state == LOAD) && bus.s_valid && bus.s_ready;
`ifdef IMEM_LOADER_VERIFY_EN
        if (rd_issue) ag_step = 1'b1;
`endif
    end

    imem_loader_addr_gen #(
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_addr_gen (
        .clk        (clk),
        .arst_n     (arst_n),
        .load       (ag_load),
        .rewind     (ag_rewind),
        .step       (ag_step),
        .base_addr  (base_addr),
        .word_count (word_count),
        .addr       (ag_addr),
        .last       (ag_last)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state         <= IDLE;
            bus.s_ready   <= 1'b0;
            bus.addr_ext  <= '0;
            bus.wen_ext   <= 1'b0;
            bus.ren_ext   <= 1'b0;
            bus.wdata_ext <= '0;
            cpu_enable    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            rd_done       <= 1'b0;
            wr_sum        <= '0;
            rd_sum        <= '0;
`endif
        end else begin
            bus.wen_ext <= 1'b0;
            bus.ren_ext <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.s_ready) begin
                        if (bus.s_valid) begin
                            bus.wen_ext   <= 1'b1;
                            bus.addr_ext  <= ag_addr;
                            bus.wdata_ext <= bus.s_data;
`ifdef IMEM_LOADER_VERIFY_EN
                            wr_sum        <= wr_sum ^ bus.s_data;
`endif
                            if (ag_last) bus.s_ready <= 1'b0;
                        end
                    end else begin
                        // s_ready low in LOAD means the final write pulse just went out
`ifdef IMEM_LOADER_VERIFY_EN
                        state   <= VERIFY;
                        rd_done <= 1'b0;
                        rd_sum  <= '0;
`else
                        state      <= RUN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_enable <= 1'b1;
`endif
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                VERIFY: begin
                    if (rd_issue) begin
                        bus.ren_ext  <= 1'b1;
                        bus.addr_ext <= ag_addr;
                        if (ag_last) rd_done <= 1'b1;
                    end
                    if (vld_pipe[RD_LAT]) begin
                        rd_sum <= rd_sum ^ bus.rdata_ext;
                        if (last_pipe[RD_LAT]) begin
                            busy <= 1'b0;
                            if ((rd_sum ^ bus.rdata_ext) == wr_sum) begin
                                state      <= RUN;
                                done       <= 1'b1;
                                cpu_enable <= 1'b1;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    // IDLE, RUN and ERR all restart identically on start
                    if (start) begin
                        cpu_enable <= 1'b0;
                        error      <= 1'b0;
                        if (word_count == '0) begin
                            state      <= RUN;
                            done       <= 1'b1;
                            cpu_enable <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            bus.s_ready <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
                            wr_sum      <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
